uart_rx_fifo_mem: RTL



---
 rtl/uart_rx_fifo_mem.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_mem.sv
// UART receive FIFO with a memory-mapped data/status register pair.
// The receiver pushes bytes with a one-cycle valid pulse; the CPU pops
// via RXDATA writes and manages overflow/flush via STATUS writes.
module uart_rx_fifo_mem #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_addr,
  input  logic              i_mem_wen,
  input  logic [31:0]       i_mem_wdata,
  output logic [31:0]       o_mem_rdata,
  input  logic              i_rx_dv,
  input  logic [DATA_W-1:0] i_rx_byte,
  output logic              o_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_irq;

  logic              w_empty;
  logic              w_full;
  logic              w_pop_req;
  logic              w_flush;
  logic              w_ovf_clr;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_evt;
  logic [CW-1:0]     w_count_next;
  logic              w_ovf_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));

  assign w_pop_req = i_mem_wen && !i_mem_addr && i_mem_wdata[31];
  assign w_flush   = i_mem_wen &&  i_mem_addr && i_mem_wdata[1];
  assign w_ovf_clr = i_mem_wen &&  i_mem_addr && i_mem_wdata[0];

  // Flush overrides everything: a same-cycle byte is discarded silently,
  // and a pop while full makes room so the same-cycle push is not an overflow.
  assign w_pop     = w_pop_req && !w_empty && !w_flush;
  assign w_push    = i_rx_dv && (!w_full || w_pop) && !w_flush;
  assign w_ovf_evt = i_rx_dv && w_full && !w_pop && !w_flush;

  // Next-state count and sticky overflow (set beats clear)
  always_comb begin
    w_count_next = r_count;
    if (w_flush)
      w_count_next = '0;
    else
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_ovf_next = r_ovf;
    if (w_ovf_evt)
      w_ovf_next = 1'b1;
    else if (w_ovf_clr)
      w_ovf_next = 1'b0;
  end

  // Pointer, count, overflow and interrupt state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
      r_irq   <= (w_count_next >= CW'(IRQ_THRESH)) | w_ovf_next;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rx_byte;
  end

  // Combinational register read mux
  always_comb begin
    o_mem_rdata = '0;
    if (!i_mem_addr) begin
      o_mem_rdata[30] = !w_empty;
      if (!w_empty) o_mem_rdata[DATA_W-1:0] = r_mem[r_rd_ptr];
    end else begin
      o_mem_rdata[31]   = r_ovf;
      o_mem_rdata[30]   = w_full;
      o_mem_rdata[29]   = w_empty;
      o_mem_rdata[15:0] = 16'(r_count);
    end
  end

  assign o_irq = r_irq;

endmodule
